// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the compute core's data port.
// It serves single-word read/write requests against an internal word-addressed
// array. Each access takes LATENCY extra wait cycles before it commits, and the
// core is stalled until the access completes.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag out-of-range addresses
// on AccessFault. When it is undefined, upper address bits wrap modulo DEPTH.
module data_mem_responder #(
  parameter int BIT_COUNT = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemEn,
  input  logic                   MemWrite,
  input  logic [BIT_COUNT/8-1:0] ByteEn,
  input  logic [BIT_COUNT-1:0]   MemAdr,
  input  logic [BIT_COUNT-1:0]   MemWriteData,
  output logic [BIT_COUNT-1:0]   MemReadData,
  output logic                   Stall
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic                   AccessFault
`endif
);

  localparam int LANES = BIT_COUNT / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [BIT_COUNT-1:0] ADDR_LIMIT = BIT_COUNT'(DEPTH * LANES);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   we_q, we_d;
  logic [LANES-1:0]       be_q, be_d;
  logic [BIT_COUNT-1:0]   wdata_q, wdata_d;
  logic                   fault_q, fault_d;
  logic [BIT_COUNT-1:0]   rdata_q, rdata_d;
  logic                   mem_we_s;
  logic                   fault_s;
  logic [BIT_COUNT-1:0]   mem_q [DEPTH];
`ifdef DMEM_BOUNDS_CHECK_EN
  logic                   afault_q, afault_d;
`endif

  // Byte-offset bits never select a word; upper bits wrap unless bounds-checked.
  logic unused_adr_s;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign unused_adr_s = ^MemAdr[OFS-1:0];
  assign fault_s      = (MemAdr >= ADDR_LIMIT);
`else
  assign unused_adr_s = ^{MemAdr[BIT_COUNT-1:OFS+IDX_W], MemAdr[OFS-1:0]};
  assign fault_s      = 1'b0;
`endif

  // Next-state logic: capture in IDLE, count down in WAIT, commit at zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    mem_we_s = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    afault_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (MemEn) begin
          idx_d   = MemAdr[OFS+IDX_W-1:OFS];
          we_d    = MemWrite;
          be_d    = ByteEn;
          wdata_d = MemWriteData;
          fault_d = fault_s;
          cnt_d   = LAT_CNT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          if (fault_q) begin
`ifdef DMEM_BOUNDS_CHECK_EN
            afault_d = 1'b1;
`endif
          end else if (we_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset discards any captured request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
      afault_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_BOUNDS_CHECK_EN
      afault_q <= afault_d;
`endif
    end
  end

  // Storage array, byte-lane writes only; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we_s && be_q[i]) begin
        mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign MemReadData = rdata_q;
  assign Stall       = reset & MemEn & (state_q != ST_DONE);
`ifdef DMEM_BOUNDS_CHECK_EN
  assign AccessFault = afault_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder. It drives two instances, one with
// LATENCY=2 and one with LATENCY=0, and compares outputs against hand-computed values.
module tb_data_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        en2, en0;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] adr_r, wd_r;
  logic [31:0] rdata2, rdata0;
  logic        stall2, stall0;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        afault2, afault0;
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rd;
  logic [31:0] words0 [3];
  logic [31:0] addrs0 [3];

  data_mem_responder #(.BIT_COUNT(32), .DEPTH(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset_n), .MemEn(en2), .MemWrite(we_r), .ByteEn(be_r),
    .MemAdr(adr_r), .MemWriteData(wd_r), .MemReadData(rdata2), .Stall(stall2)
`ifdef DMEM_BOUNDS_CHECK_EN
    , .AccessFault(afault2)
`endif
  );

  data_mem_responder #(.BIT_COUNT(32), .DEPTH(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset_n), .MemEn(en0), .MemWrite(we_r), .ByteEn(be_r),
    .MemAdr(adr_r), .MemWriteData(wd_r), .MemReadData(rdata0), .Stall(stall0)
`ifdef DMEM_BOUNDS_CHECK_EN
    , .AccessFault(afault0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; returns read data seen in DONE.
  task automatic access2(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] be, input bit churn, input string tag,
                         output logic [31:0] rd);
    int hi;
    bit done;
    hi = 0;
    done = 1'b0;
    rd = 32'h0;
    @(posedge clk); #1;
    en2 = 1'b1; we_r = we; adr_r = adr; wd_r = wd; be_r = be;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stall2) begin
        done = 1'b1;
        break;
      end
      hi++;
`ifdef DMEM_BOUNDS_CHECK_EN
      if (c == 0) check_val({tag, " afault low"}, 64'(afault2), 64'd0);
`endif
      if (churn && c == 1) begin
        adr_r = adr ^ 32'h0000_0004;
        wd_r  = ~wd;
      end
    end
    check_val({tag, " done seen"}, 64'(done), 64'd1);
    check_val({tag, " stall cycles"}, 64'(hi), 64'd4);
`ifdef DMEM_BOUNDS_CHECK_EN
    check_val({tag, " afault done"}, 64'(afault2), 64'(adr >= 32'h0000_1000));
`endif
    rd = rdata2;
    @(posedge clk); #1;
    en2 = 1'b0;
  endtask

  // LATENCY=0 instance with MemEn held high for three requests in a row.
  task automatic burst0(input logic we, input string tag);
    @(posedge clk); #1;
    en0 = 1'b1; we_r = we; be_r = 4'hF; adr_r = addrs0[0]; wd_r = words0[0];
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check_val({tag, " stall pattern"}, 64'(stall0), 64'((c % 3) != 2));
      if ((c % 3) == 2) begin
        if (!we) check_val({tag, " read word"}, 64'(rdata0), 64'(words0[c/3]));
        if (c < 8) begin
          adr_r = addrs0[c/3 + 1];
          wd_r  = words0[c/3 + 1];
        end else begin
          en0 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    reset_n = 1'b0; en2 = 1'b1; en0 = 1'b1; we_r = 1'b0; be_r = 4'h0;
    adr_r = 32'h0; wd_r = 32'h0;
    addrs0[0] = 32'h10; addrs0[1] = 32'h14; addrs0[2] = 32'h18;
    words0[0] = 32'hA0A0_0001; words0[1] = 32'hB0B0_0002; words0[2] = 32'hC0C0_0003;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset stall2", 64'(stall2), 64'd0);
    check_val("reset stall0", 64'(stall0), 64'd0);
    check_val("reset rdata2", 64'(rdata2), 64'd0);
    check_val("reset rdata0", 64'(rdata0), 64'd0);
    @(negedge clk);
    en2 = 1'b0; en0 = 1'b0;
    reset_n = 1'b1;

    // Known value at 0x40, then a write interrupted by reset in WAIT.
    access2(1'b1, 32'h40, 32'h1111_1111, 4'hF, 1'b0, "pre wr", rd);
    access2(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, "pre rd", rd);
    check_val("pre rd data", 64'(rd), 64'h1111_1111);
    @(posedge clk); #1;
    en2 = 1'b1; we_r = 1'b1; adr_r = 32'h40; wd_r = 32'hDEAD_BEEF; be_r = 4'hF;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst stall", 64'(stall2), 64'd0);
    check_val("midrst rdata", 64'(rdata2), 64'd0);
    @(negedge clk);
    en2 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    access2(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, "post rst rd", rd);
    check_val("no commit after rst", 64'(rd), 64'h1111_1111);

    // Full write, read back, partial byte-enable update.
    access2(1'b1, 32'h100, 32'h1234_5678, 4'hF, 1'b0, "full wr", rd);
    access2(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, "full rd", rd);
    check_val("full rd data", 64'(rd), 64'h1234_5678);
    access2(1'b1, 32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0, "be wr", rd);
    check_val("wr keeps rdata", 64'(rd), 64'h1234_5678);
    access2(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, "be rd", rd);
    check_val("be rd data", 64'(rd), 64'h12BB_56DD);
    access2(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, "be0 wr", rd);
    access2(1'b0, 32'h103, 32'h0, 4'h0, 1'b0, "be0 rd", rd);
    check_val("be0 and offset rd", 64'(rd), 64'h12BB_56DD);

    // Input churn during WAIT must not affect the captured request.
    access2(1'b1, 32'h204, 32'h0BAD_C0DE, 4'hF, 1'b0, "pre204 wr", rd);
    access2(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 1'b1, "churn wr", rd);
    access2(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, "churn rd200", rd);
    check_val("churn addr200", 64'(rd), 64'hCAFE_F00D);
    access2(1'b0, 32'h204, 32'h0, 4'h0, 1'b0, "churn rd204", rd);
    check_val("churn addr204", 64'(rd), 64'h0BAD_C0DE);

    // Out-of-range addresses: wrap by default, fault when bounds-checked.
    access2(1'b1, 32'h0, 32'h55AA_55AA, 4'hF, 1'b0, "w0 wr", rd);
    access2(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, "oor pre rd", rd);
    access2(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, "oor rd", rd);
    check_val("oor rd data", 64'(rd), BOUNDS ? 64'h12BB_56DD : 64'h55AA_55AA);
    access2(1'b1, 32'h1000, 32'h7777_7777, 4'hF, 1'b0, "oor wr", rd);
    access2(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, "oor chk rd", rd);
    check_val("oor wr effect", 64'(rd), BOUNDS ? 64'h55AA_55AA : 64'h7777_7777);

    // Zero-latency back-to-back writes then reads.
    burst0(1'b1, "b2b wr");
    burst0(1'b0, "b2b rd");
`ifdef DMEM_BOUNDS_CHECK_EN
    check_val("lat0 afault idle", 64'(afault0), 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the compute core's data port. It services MemEn/MemWrite/ByteEn/MemAdr/MemWriteData requests against an internal word-addressed array.
- Read data returns on MemReadData after a programmable number of wait states.
- Stall holds the core until each access completes.
- Sits between computeCore's data-memory pins and the top level; replaces the ideal zero-latency memory model.

Parameters:
- BIT_COUNT, 32: data/address width; must be 32 or 64.
- DEPTH, 1024: number of BIT_COUNT-wide words; power of two.
- LATENCY, 2: extra wait cycles before an access commits (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- MemEn  input  1  access request from core.
- MemWrite  input  1  1 = write, 0 = read; valid with MemEn.
- ByteEn  input  BIT_COUNT/8  per-byte write enables; ignored on reads.
- MemAdr  input  BIT_COUNT  byte address.
- MemWriteData  input  BIT_COUNT  write data.
- MemReadData  output  BIT_COUNT  registered read data.
- Stall  output  1  core must hold its request while high.
- AccessFault  output  1  out-of-range flag; present only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; wait counter = 0; MemReadData = 0; Stall = 0; AccessFault = 0.
  - Any captured request is discarded, and a pending write never commits.
  - The memory array is not reset.
- Word index = MemAdr[OFS+log2(DEPTH)-1 : OFS], where OFS = log2(BIT_COUNT/8). Offset bits below OFS are ignored.
- State machine (IDLE, WAIT, DONE):
  - IDLE: on an edge with MemEn=1, capture index, MemWrite, ByteEn and MemWriteData; load counter = LATENCY; go to WAIT. With MemEn=0, stay in IDLE.
  - WAIT: on an edge with counter != 0, decrement. On an edge with counter == 0, perform the access and go to DONE.
    - Write: each byte lane i with ByteEn[i]=1 updates from captured data; other lanes keep their value.
    - Read: MemReadData <= array[index].
  - DONE: one cycle. On the next edge, go to IDLE. A request present in DONE is not accepted; it is accepted in the following IDLE cycle.
- Input changes while in WAIT are ignored; captured values govern the access.
- Stall = MemEn & (state != DONE), combinational; forced to 0 while reset is asserted.
- Timing for a request raised in cycle 0 from IDLE:
  - Stall is high for LATENCY+2 cycles.
  - DONE occurs in cycle LATENCY+2, with Stall low; read data is valid in that cycle.
- MemReadData holds the last completed read. Writes and idle cycles do not alter it.
- A write with ByteEn = 0 completes normally with no array change.
- A read to a word written earlier returns the updated value; there is no stale read.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A request with MemAdr >= DEPTH*(BIT_COUNT/8) is flagged at capture.
  - The access performs no array write and no MemReadData update.
  - AccessFault = 1 during that request's DONE cycle and 0 otherwise.
  - Handshake timing is unchanged.
- Undefined:
  - No AccessFault port.
  - Upper address bits are dropped, so addresses wrap modulo DEPTH words.

Test Plan:
- Reset mid-write: LATENCY=2, write 0xDEADBEEF to 0x40 with ByteEn=0xF; drop reset in the first WAIT cycle -> Stall=0, MemReadData=0; a later read of 0x40 does not return 0xDEADBEEF.
- Full write then read: LATENCY=2, write 0x12345678 to 0x100 with ByteEn=0xF, then read 0x100 -> each request has Stall high 4 cycles, low in DONE; MemReadData=0x12345678 in the read's DONE cycle.
- Byte enables: 0x12345678 at 0x100; write 0xAABBCCDD with ByteEn=0b0101, then read -> 0x12BB56DD.
- Zero latency and back-to-back: LATENCY=0, MemEn held high for 3 reads -> Stall pattern 1,1,0 repeating with one IDLE between; each DONE shows the correct word.
- Input churn in WAIT: change MemAdr and MemWriteData during WAIT -> the captured address and data are written.
- Out of range: read at 0x1000 with DEPTH=1024 -> with DMEM_BOUNDS_CHECK_EN, AccessFault=1 in DONE and MemReadData unchanged; without it, returns the word at 0x0.
